// File: rtl/bit_count_ctrl_if.sv
// Handshake and datapath-control bundle between bit_count_ctrl and its
// environment: datapath status flags in, datapath controls out, plus the
// start request and the result valid/ready handshake.
interface bit_count_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    // request / result handshake
    logic             start;
    logic             result_ready;
    logic             result_valid;
    logic [CNT_W-1:0] result;
    logic             busy;
    logic             err;

    // datapath status flags
    logic             A_zero;
    logic             A_0;
    logic [CNT_W-1:0] count_in;

    // datapath controls
    logic             setA;
    logic             resetResult;
    logic             shiftA;
    logic             incrResult;

    // Controller side
    modport slave (
        input  start,
        input  result_ready,
        input  A_zero,
        input  A_0,
        input  count_in,
        output result_valid,
        output result,
        output busy,
        output err,
        output setA,
        output resetResult,
        output shiftA,
        output incrResult
    );

    // Environment side (requester plus datapath)
    modport master (
        output start,
        output result_ready,
        output A_zero,
        output A_0,
        output count_in,
        input  result_valid,
        input  result,
        input  busy,
        input  err,
        input  setA,
        input  resetResult,
        input  shiftA,
        input  incrResult
    );
endinterface

// File: rtl/bit_count_ctrl.sv
// Controller for the ones-counting datapath. Loads A and clears the counter
// while idle, shifts A and counts set LSBs until A reaches zero, then offers
// the captured count on a valid/ready handshake. A watchdog aborts to an
// error state if A never reaches zero within WIDTH+1 counting cycles.
module bit_count_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input logic             clk,
    input logic             reset_n,
    bit_count_ctrl_if.slave bus
);

    localparam int unsigned     WD_W     = $clog2(WIDTH + 2);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic [CNT_W-1:0] result_q, result_d;

    logic set_a;
    logic reset_result;
    logic shift_a;
    logic incr_result;
    logic busy;
    logic result_valid;
    logic err;

    // State, watchdog and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wd_cnt_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            wd_cnt_q <= wd_cnt_d;
            result_q <= result_d;
        end
    end

    // Next-state, watchdog/result update and output decode (incrResult is Mealy)
    always_comb begin
        state_d      = state_q;
        wd_cnt_d     = '0;
        result_d     = result_q;
        set_a        = 1'b0;
        reset_result = 1'b0;
        shift_a      = 1'b0;
        incr_result  = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        err          = 1'b0;

        case (state_q)
            S_IDLE: begin
                set_a        = 1'b1;
                reset_result = 1'b1;
                if (bus.start) begin
                    state_d = S_COUNT;
                end
            end

            S_COUNT: begin
                busy        = 1'b1;
                shift_a     = 1'b1;
                incr_result = bus.A_0 & ~bus.A_zero;
                wd_cnt_d    = wd_cnt_q + 1'b1;
                // A reaching zero wins over a watchdog expiring on the same cycle
                if (bus.A_zero) begin
                    state_d  = S_DONE;
                    result_d = bus.count_in;
                end else if (wd_cnt_q == WD_LIMIT) begin
                    state_d = S_ERR;
                end
            end

            S_DONE: begin
                result_valid = 1'b1;
                // A still-high start blocks a re-trigger until it has dropped
                if (bus.result_ready && !bus.start) begin
                    state_d = S_IDLE;
                end
            end

            S_ERR: begin
                err = 1'b1;
                if (!bus.start) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.setA         = set_a;
    assign bus.resetResult  = reset_result;
    assign bus.shiftA       = shift_a;
    assign bus.incrResult   = incr_result;
    assign bus.busy         = busy;
    assign bus.result_valid = result_valid;
    assign bus.result       = result_q;
    assign bus.err          = err;

endmodule

// File: tb/tb_bit_count_ctrl.sv
// Self-checking bench for bit_count_ctrl with a behavioural ones-counting
// datapath; expected counts and latencies come from popcount / highest-set-bit
// arithmetic on the operand.
module tb_bit_count_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] A_in;
    bit         stub;

    logic [7:0] dp_a;
    logic [3:0] dp_cnt;

    int unsigned checks = 0;
    int unsigned passes = 0;

    bit_count_ctrl_if #(.CNT_W(4)) bus ();

    bit_count_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural datapath driven by the controller
    always @(posedge clk) begin
        if (bus.setA)            dp_a <= A_in;
        else if (bus.shiftA)     dp_a <= dp_a >> 1;
        if (bus.resetResult)     dp_cnt <= '0;
        else if (bus.incrResult) dp_cnt <= dp_cnt + 4'd1;
    end

    assign bus.A_zero   = stub ? 1'b0 : (dp_a == 8'd0);
    assign bus.A_0      = stub ? 1'b1 : dp_a[0];
    assign bus.count_in = dp_cnt;

    function automatic logic [3:0] ref_popcount(input logic [7:0] a);
        int unsigned c = 0;
        for (int i = 0; i < 8; i++) c += a[i];
        return 4'(c);
    endfunction

    function automatic int unsigned ref_cycles(input logic [7:0] a);
        int unsigned k = 0;
        if (a == 8'd0) return 1;
        for (int i = 0; i < 8; i++) if (a[i]) k = i;
        return k + 2;
    endfunction

    // Start a run and follow it through S_COUNT, checking per-cycle controls
    task automatic run_op(input logic [7:0] a, input bit use_stub, input bit keep_start);
        int unsigned exp_cyc;
        int unsigned n;
        logic        exp_inc;
        logic [3:0]  exp_res;
        exp_cyc = use_stub ? 9 : ref_cycles(a);
        exp_res = ref_popcount(a);
        A_in = a;
        stub = use_stub;
        bus.start = 1'b1;
        @(negedge clk);
        if (!keep_start) bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            exp_inc = use_stub ? 1'b1 : ((n < 8) ? a[n[2:0]] : 1'b0);
            checks++;
            if (bus.incrResult !== exp_inc)
                $display("FAIL incr a=%h cyc=%0d got=%b exp=%b", a, n, bus.incrResult, exp_inc);
            else passes++;
            checks++;
            if (bus.shiftA !== 1'b1 || bus.setA !== 1'b0)
                $display("FAIL count_ctl a=%h cyc=%0d shiftA=%b setA=%b exp 1/0", a, n, bus.shiftA, bus.setA);
            else passes++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != exp_cyc) $display("FAIL count_len a=%h got=%0d exp=%0d", a, n, exp_cyc);
        else passes++;
        if (use_stub) begin
            checks++;
            if (bus.err !== 1'b1 || bus.result_valid !== 1'b0)
                $display("FAIL wd_err err=%b valid=%b exp 1/0", bus.err, bus.result_valid);
            else passes++;
        end else begin
            checks++;
            if (bus.result_valid !== 1'b1 || bus.err !== 1'b0)
                $display("FAIL done a=%h valid=%b err=%b exp 1/0", a, bus.result_valid, bus.err);
            else passes++;
            checks++;
            if (bus.result !== exp_res)
                $display("FAIL result a=%h got=%0d exp=%0d", a, bus.result, exp_res);
            else passes++;
        end
    endtask

    // Accept the result with start low; controller must return to S_IDLE next edge
    task automatic finish_handshake();
        bus.result_ready = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.result_ready = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b0 || bus.setA !== 1'b1 || bus.resetResult !== 1'b1)
            $display("FAIL to_idle valid=%b setA=%b resetResult=%b exp 0/1/1",
                     bus.result_valid, bus.setA, bus.resetResult);
        else passes++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (bus.setA !== 1'b1 || bus.resetResult !== 1'b1 || bus.shiftA !== 1'b0 ||
            bus.incrResult !== 1'b0 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0 ||
            bus.err !== 1'b0 || bus.result !== 4'd0)
            $display("FAIL reset setA=%b rr=%b sh=%b inc=%b busy=%b valid=%b err=%b result=%0d exp 1/1/0/0/0/0/0/0",
                     bus.setA, bus.resetResult, bus.shiftA, bus.incrResult, bus.busy,
                     bus.result_valid, bus.err, bus.result);
        else passes++;
    endtask

    task automatic test_directed();
        run_op(8'h03, 1'b0, 1'b0);
        finish_handshake();
        run_op(8'h00, 1'b0, 1'b0);
        finish_handshake();
        run_op(8'h80, 1'b0, 1'b0);
        finish_handshake();
    endtask

    task automatic test_hold();
        run_op(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.result_valid !== 1'b1 || bus.result !== 4'd8)
                $display("FAIL hold cyc=%0d valid=%b result=%0d exp 1/8", i, bus.result_valid, bus.result);
            else passes++;
        end
        finish_handshake();
    endtask

    task automatic test_reset_midrun();
        A_in = 8'h1F;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL midrun_busy got=%b exp=1", bus.busy);
        else passes++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (bus.setA !== 1'b1 || bus.result !== 4'd0 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0)
            $display("FAIL midrun_reset setA=%b result=%0d busy=%b valid=%b exp 1/0/0/0",
                     bus.setA, bus.result, bus.busy, bus.result_valid);
        else passes++;
    endtask

    task automatic test_watchdog();
        run_op(8'h55, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1 || bus.setA !== 1'b0 || bus.resetResult !== 1'b0 ||
            bus.shiftA !== 1'b0 || bus.incrResult !== 1'b0)
            $display("FAIL err_hold err=%b setA=%b rr=%b sh=%b inc=%b exp 1/0/0/0/0",
                     bus.err, bus.setA, bus.resetResult, bus.shiftA, bus.incrResult);
        else passes++;
        bus.start = 1'b0;
        @(negedge clk);
        stub = 1'b0;
        checks++;
        if (bus.err !== 1'b0 || bus.setA !== 1'b1)
            $display("FAIL err_exit err=%b setA=%b exp 0/1", bus.err, bus.setA);
        else passes++;
    endtask

    task automatic test_back_to_back();
        run_op(8'hA5, 1'b0, 1'b1);
        bus.result_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.result_valid !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 4'd4)
                $display("FAIL no_retrigger cyc=%0d valid=%b busy=%b result=%0d exp 1/0/4",
                         i, bus.result_valid, bus.busy, bus.result);
            else passes++;
        end
        finish_handshake();
        run_op(8'h3C, 1'b0, 1'b0);
        finish_handshake();
    endtask

    task automatic test_random();
        logic [7:0] a;
        int unsigned wait_cyc;
        for (int t = 0; t < 24; t++) begin
            a = 8'($urandom);
            run_op(a, 1'b0, 1'b0);
            wait_cyc = $urandom_range(0, 3);
            for (int w = 0; w < int'(wait_cyc); w++) @(negedge clk);
            checks++;
            if (bus.result_valid !== 1'b1 || bus.result !== ref_popcount(a))
                $display("FAIL rand_hold a=%h valid=%b result=%0d exp 1/%0d",
                         a, bus.result_valid, bus.result, ref_popcount(a));
            else passes++;
            finish_handshake();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d passes=%0d", checks, passes);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset_n = 1'b0;
        A_in = 8'h00;
        stub = 1'b0;
        bus.start = 1'b0;
        bus.result_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_hold();
        test_reset_midrun();
        test_watchdog();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
